// File: rtl/dot11_tx_sig_enc.sv
`default_nettype none
// ============================================================================
// Module      : dot11_tx_sig_enc
// Description : Legacy 802.11 SIGNAL field builder and K=7 rate-1/2
//               convolutional encoder with valid/ready pair output.
// Revision    : 1.0 - initial release
// ============================================================================

module dot11_tx_sig_enc (
    input  logic        clock,
    input  logic        rstn,
    input  logic        enable,
    input  logic        start,
    input  logic [3:0]  rate,
    input  logic [11:0] len,
    input  logic        out_ready,
    output logic        busy,
    output logic [23:0] sig_bits,
    output logic [1:0]  coded_out,
    output logic        coded_valid,
    output logic        done_strobe,
    output logic        rate_err_strobe
);

    // Tap masks over the window {s[5:0], b}: bit 0 is the current input bit,
    // bit i+1 is s[i].
    localparam logic [6:0] c_G0_TAPS  = 7'b1101101;
    localparam logic [6:0] c_G1_TAPS  = 7'b1001111;
    localparam logic [4:0] c_LAST_BIT = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sig_q, sig_d;
    logic [5:0]  sreg_q, sreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rate_err_q, rate_err_d;

    logic        rate_legal;
    logic        parity;
    logic [23:0] sig_new;
    logic        cur_bit;
    logic [6:0]  window;

    // The eight legal legacy rate codes are exactly those with rate[3] set.
    assign rate_legal = rate[3];
    assign parity     = (^len) ^ (^rate);
    assign sig_new    = {6'b000000, parity, len, 1'b0, rate};
    assign cur_bit    = sig_q[cnt_q];
    assign window     = {sreg_q, cur_bit};

    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        rate_err_d = rate_err_q;
        if (enable) begin
            rate_err_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (rate_legal) begin
                            sig_d   = sig_new;
                            sreg_d  = 6'd0;
                            cnt_d   = 5'd0;
                            state_d = ST_ENCODE;
                        end else begin
                            rate_err_d = 1'b1;
                        end
                    end
                end
                ST_ENCODE: begin
                    if (out_ready) begin
                        sreg_d = {sreg_q[4:0], cur_bit};
                        if (cnt_q == c_LAST_BIT) begin
                            cnt_d   = 5'd0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            sig_q      <= 24'd0;
            sreg_q     <= 6'd0;
            cnt_q      <= 5'd0;
            rate_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            rate_err_q <= rate_err_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them
    // immediately and a stall or freeze holds them without extra flops.
    assign busy            = (state_q != ST_IDLE);
    assign coded_valid     = (state_q == ST_ENCODE);
    assign done_strobe     = (state_q == ST_DONE);
    assign rate_err_strobe = rate_err_q;
    assign sig_bits        = sig_q;
    assign coded_out       = coded_valid ? {^(window & c_G1_TAPS), ^(window & c_G0_TAPS)}
                                         : 2'b00;

endmodule

`default_nettype wire
